pos_ring_inject_ctrl: RTL and testbench

POS_RING_INJECT_CTRL -- requirements
Module: pos_ring_inject_ctrl

---
 rtl/MD_pkg.sv | 15 +
 rtl/pos_ring_inject_ctrl.sv | 157 +++++++++++++++
 tb/tb_pos_ring_inject_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/MD_pkg.sv
// Shared widths and types for the MD particle datapath.
package MD_pkg;

    localparam int PARTICLE_ID_WIDTH       = 8;
    localparam int GLOBAL_CELL_ID_WIDTH    = 4;
    localparam int OFFSET_PKT_STRUCT_WIDTH = 24;

    typedef enum logic [1:0] {
        IDLE,
        INJECT,
        DRAIN,
        DONE
    } inject_state_t;

endpackage

// File: rtl/pos_ring_inject_ctrl.sv
// Streams cached particle positions into the local ring node, retrying
// packets the ring rejects, then drains before signalling completion.
module pos_ring_inject_ctrl
    import MD_pkg::*;
#(
    parameter int DRAIN_CYCLES = 32,
    parameter int ADDR_W       = PARTICLE_ID_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_start,
    input  logic [ADDR_W-1:0]                  i_particle_count,
    input  logic [3*GLOBAL_CELL_ID_WIDTH-1:0]  i_home_gcid,
    output logic                               o_rd_en,
    output logic [ADDR_W-1:0]                  o_rd_addr,
    input  logic [OFFSET_PKT_STRUCT_WIDTH-1:0] i_rd_data,
    input  logic                               i_dispatcher_back_pressure,
    input  logic                               i_dirty_feedback,
    output logic [OFFSET_PKT_STRUCT_WIDTH-1:0] o_local_offset_pkt,
    output logic [3*GLOBAL_CELL_ID_WIDTH-1:0]  o_local_gcid,
    output logic                               o_local_valid,
    output logic                               o_busy,
    output logic                               o_done
);

    localparam int GW = 3 * GLOBAL_CELL_ID_WIDTH;
    localparam int PW = OFFSET_PKT_STRUCT_WIDTH;
    localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
    localparam logic [DW-1:0] D_ONE  = DW'(1);
    localparam logic [DW-1:0] D_LOAD = DW'(DRAIN_CYCLES - 1);

    inject_state_t state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] acc_q, acc_d;
    logic [GW-1:0]     gcid_q, gcid_d;
    logic [PW-1:0]     hold_q, hold_d;
    logic [PW-1:0]     skid_q, skid_d;
    logic              hold_v_q, hold_v_d;
    logic              skid_v_q, skid_v_d;
    logic              pend_q, pend_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic              accept;
    logic              issue;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            acc_q    <= '0;
            gcid_q   <= '0;
            hold_q   <= '0;
            skid_q   <= '0;
            hold_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            pend_q   <= 1'b0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            acc_q    <= acc_d;
            gcid_q   <= gcid_d;
            hold_q   <= hold_d;
            skid_q   <= skid_d;
            hold_v_q <= hold_v_d;
            skid_v_q <= skid_v_d;
            pend_q   <= pend_d;
            drain_q  <= drain_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        acc_d    = acc_q;
        gcid_d   = gcid_q;
        hold_d   = hold_q;
        skid_d   = skid_q;
        hold_v_d = hold_v_q;
        skid_v_d = skid_v_q;
        drain_d  = drain_q;

        accept = hold_v_q & ~i_dirty_feedback;
        issue  = (state_q == INJECT)
               & ~i_dispatcher_back_pressure
               & (addr_q != cnt_q)
               & (~hold_v_q | accept);
        pend_d = issue;

        if (issue) begin
            addr_d = addr_q + A_ONE;
        end

        // A read issued while the previous one is still in flight can land
        // on a rejected packet; the skid slot catches that single overlap.
        if (accept) begin
            acc_d = acc_q + A_ONE;
            if (skid_v_q) begin
                hold_d   = skid_q;
                skid_v_d = 1'b0;
            end else if (pend_q) begin
                hold_d = i_rd_data;
            end else begin
                hold_v_d = 1'b0;
            end
        end else if (pend_q) begin
            if (hold_v_q) begin
                skid_d   = i_rd_data;
                skid_v_d = 1'b1;
            end else begin
                hold_d   = i_rd_data;
                hold_v_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    cnt_d   = i_particle_count;
                    gcid_d  = i_home_gcid;
                    addr_d  = '0;
                    acc_d   = '0;
                    state_d = (i_particle_count == '0) ? DONE : INJECT;
                end
            end
            INJECT: begin
                if (accept && (acc_q + A_ONE == cnt_q)) begin
                    drain_d = D_LOAD;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q - D_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_rd_en            = issue;
    assign o_rd_addr          = addr_q;
    assign o_local_valid      = hold_v_q;
    assign o_local_offset_pkt = hold_q;
    assign o_local_gcid       = gcid_q;
    assign o_busy             = (state_q == INJECT) || (state_q == DRAIN);
    assign o_done             = (state_q == DONE);

endmodule

// File: tb/tb_pos_ring_inject_ctrl.sv
// Directed scenario bench for pos_ring_inject_ctrl with a one-cycle
// latency position-cache model.
module tb_pos_ring_inject_ctrl;
    import MD_pkg::*;

    localparam int DR = 4;
    localparam int AW = PARTICLE_ID_WIDTH;
    localparam int GW = 3 * GLOBAL_CELL_ID_WIDTH;
    localparam int PW = OFFSET_PKT_STRUCT_WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] cnt;
    logic [GW-1:0] gcid;
    logic [PW-1:0] rd_data = '0;
    logic          bp;
    logic          dirty;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [PW-1:0] pkt;
    logic [GW-1:0] lgcid;
    logic          lvalid;
    logic          busy;
    logic          done;

    int total = 0;
    int bad = 0;

    pos_ring_inject_ctrl #(
        .DRAIN_CYCLES(DR),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_start(start),
        .i_particle_count(cnt),
        .i_home_gcid(gcid),
        .o_rd_en(rd_en),
        .o_rd_addr(rd_addr),
        .i_rd_data(rd_data),
        .i_dispatcher_back_pressure(bp),
        .i_dirty_feedback(dirty),
        .o_local_offset_pkt(pkt),
        .o_local_gcid(lgcid),
        .o_local_valid(lvalid),
        .o_busy(busy),
        .o_done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] mkpkt(input logic [AW-1:0] a);
        return PW'({16'hBEEF, a});
    endfunction

    // Cache model: data for the requested address appears one cycle later.
    always @(posedge clk) begin
        rd_data <= rd_en ? mkpkt(rd_addr) : '0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        total += 7;
        if (rd_en !== 1'b0) begin
            bad++; $display("FAIL rst_rd_en got=%b want=0", rd_en);
        end
        if (rd_addr !== '0) begin
            bad++; $display("FAIL rst_rd_addr got=%0d want=0", rd_addr);
        end
        if (lvalid !== 1'b0) begin
            bad++; $display("FAIL rst_valid got=%b want=0", lvalid);
        end
        if (pkt !== '0) begin
            bad++; $display("FAIL rst_pkt got=%h want=0", pkt);
        end
        if (lgcid !== '0) begin
            bad++; $display("FAIL rst_gcid got=%h want=0", lgcid);
        end
        if (busy !== 1'b0) begin
            bad++; $display("FAIL rst_busy got=%b want=0", busy);
        end
        if (done !== 1'b0) begin
            bad++; $display("FAIL rst_done got=%b want=0", done);
        end
    endtask

    task automatic test_basic();
        int n;
        tick(); start = 1'b1; cnt = 8'd4; gcid = 12'h5A3;
        tick(); start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) tick();
            #1;
            total++;
            if (rd_en !== 1'(c < 4) || (c < 4 && rd_addr !== AW'(c))) begin
                bad++;
                $display("FAIL basic_rd c=%0d got en=%b addr=%0d want en=%b addr=%0d",
                         c, rd_en, rd_addr, c < 4, c);
            end
            total++;
            if (lvalid !== 1'(c >= 2) ||
                (c >= 2 && (pkt !== mkpkt(AW'(c - 2)) || lgcid !== 12'h5A3))) begin
                bad++;
                $display("FAIL basic_pkt c=%0d got v=%b pkt=%h gcid=%h want v=%b",
                         c, lvalid, pkt, lgcid, c >= 2);
            end
        end
        n = 0;
        do begin
            tick(); #1; n++;
        end while (done !== 1'b1 && n < 50);
        total++;
        if (n != DR + 1) begin
            bad++; $display("FAIL basic_done_lat got=%0d want=%0d", n, DR + 1);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL basic_busy_at_done got=%b want=0", busy);
        end
        tick(); #1;
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL basic_done_pulse got=%b want=0", done);
        end
    endtask

    task automatic test_dirty();
        int d_in[7]  = '{0, 1, 1, 1, 0, 0, 0};
        int e_rd[7]  = '{1, 1, 0, 0, 1, 0, 0};
        int e_ad[7]  = '{0, 1, 0, 0, 2, 0, 0};
        int e_v[7]   = '{0, 0, 1, 1, 1, 1, 1};
        int e_pk[7]  = '{0, 0, 0, 0, 0, 1, 2};
        int n;
        tick(); start = 1'b1; cnt = 8'd3; gcid = 12'h0C7;
        tick(); start = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) tick();
            dirty = 1'(d_in[c]);
            #1;
            total++;
            if (rd_en !== 1'(e_rd[c]) || (e_rd[c] == 1 && rd_addr !== AW'(e_ad[c]))) begin
                bad++;
                $display("FAIL dirty_rd c=%0d got en=%b addr=%0d want en=%0d addr=%0d",
                         c, rd_en, rd_addr, e_rd[c], e_ad[c]);
            end
            total++;
            if (lvalid !== 1'(e_v[c]) ||
                (e_v[c] == 1 && pkt !== mkpkt(AW'(e_pk[c])))) begin
                bad++;
                $display("FAIL dirty_pkt c=%0d got v=%b pkt=%h want v=%0d pkt=%h",
                         c, lvalid, pkt, e_v[c], mkpkt(AW'(e_pk[c])));
            end
        end
        dirty = 1'b0;
        n = 0;
        do begin
            tick(); #1; n++;
        end while (done !== 1'b1 && n < 50);
        total++;
        if (n != DR + 1) begin
            bad++; $display("FAIL dirty_done_lat got=%0d want=%0d", n, DR + 1);
        end
    endtask

    task automatic test_backpressure();
        int b_in[12] = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        int e_rd[12] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
        int e_ad[12] = '{0, 1, 0, 0, 0, 0, 0, 2, 3, 4, 0, 0};
        int e_v[12]  = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
        int e_pk[12] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 3, 4};
        int n;
        tick(); start = 1'b1; cnt = 8'd5; gcid = 12'h9E1;
        tick(); start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) tick();
            bp = 1'(b_in[c]);
            #1;
            total++;
            if (rd_en !== 1'(e_rd[c]) || (e_rd[c] == 1 && rd_addr !== AW'(e_ad[c]))) begin
                bad++;
                $display("FAIL bp_rd c=%0d got en=%b addr=%0d want en=%0d addr=%0d",
                         c, rd_en, rd_addr, e_rd[c], e_ad[c]);
            end
            total++;
            if (lvalid !== 1'(e_v[c]) ||
                (e_v[c] == 1 && (pkt !== mkpkt(AW'(e_pk[c])) || lgcid !== 12'h9E1))) begin
                bad++;
                $display("FAIL bp_pkt c=%0d got v=%b pkt=%h want v=%0d pkt=%h",
                         c, lvalid, pkt, e_v[c], mkpkt(AW'(e_pk[c])));
            end
        end
        bp = 1'b0;
        n = 0;
        do begin
            tick(); #1; n++;
        end while (done !== 1'b1 && n < 50);
        total++;
        if (n != DR + 1) begin
            bad++; $display("FAIL bp_done_lat got=%0d want=%0d", n, DR + 1);
        end
    endtask

    task automatic test_zero();
        tick(); start = 1'b1; cnt = 8'd0; gcid = 12'h001;
        #1;
        total++;
        if (rd_en !== 1'b0) begin
            bad++; $display("FAIL zero_rd got=%b want=0", rd_en);
        end
        tick(); start = 1'b0;
        #1;
        total++;
        if (done !== 1'b1 || rd_en !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_done got done=%b rd=%b busy=%b want 1/0/0", done, rd_en, busy);
        end
        tick(); #1;
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL zero_done_pulse got=%b want=0", done);
        end
    endtask

    task automatic test_reset_mid();
        int nrd = 0;
        int nacc = 0;
        int ndone = 0;
        tick(); start = 1'b1; cnt = 8'd8; gcid = 12'h111;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        #1 rst = 1'b1;
        test_reset();
        #1 rst = 1'b0;
        tick(); #1;
        total++;
        if (lvalid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rmid_discard got v=%b busy=%b want 0/0", lvalid, busy);
        end
        tick(); start = 1'b1; cnt = 8'd2; gcid = 12'h222;
        tick(); start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) tick();
            #1;
            if (rd_en === 1'b1) begin
                total++;
                if (rd_addr !== AW'(nrd)) begin
                    bad++; $display("FAIL rmid_addr got=%0d want=%0d", rd_addr, nrd);
                end
                nrd++;
            end
            if (lvalid === 1'b1) begin
                total++;
                if (pkt !== mkpkt(AW'(nacc)) || lgcid !== 12'h222) begin
                    bad++;
                    $display("FAIL rmid_pkt got=%h gcid=%h want=%h gcid=222",
                             pkt, lgcid, mkpkt(AW'(nacc)));
                end
                nacc++;
            end
            if (done === 1'b1) ndone++;
        end
        total++;
        if (nrd != 2 || nacc != 2 || ndone != 1) begin
            bad++;
            $display("FAIL rmid_counts got rd=%0d acc=%0d done=%0d want 2/2/1", nrd, nacc, ndone);
        end
    endtask

    task automatic test_start_in_drain();
        int nrd = 0;
        int ndone = 0;
        tick(); start = 1'b1; cnt = 8'd1; gcid = 12'h333;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        start = 1'b1; cnt = 8'd3;
        #1;
        total++;
        if (busy !== 1'b1 || lvalid !== 1'b0) begin
            bad++; $display("FAIL drain_state got busy=%b v=%b want 1/0", busy, lvalid);
        end
        tick(); start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) tick();
            #1;
            if (rd_en === 1'b1) nrd++;
            if (done === 1'b1) ndone++;
        end
        total++;
        if (nrd != 0 || ndone != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL drain_start got rd=%0d done=%0d busy=%b want 0/1/0", nrd, ndone, busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cnt = '0;
        gcid = '0;
        bp = 1'b0;
        dirty = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        rst = 1'b0;
        test_basic();
        test_dirty();
        test_backpressure();
        test_zero();
        test_reset_mid();
        test_start_in_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
